// File: rtl/vc_test_source_pkg.sv
// Shared types for vc_test_source_multi: channel FSM states and the delay LFSR.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Ports: none.
package vc_test_source_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SEND,
    DONE
  } state_e;

  localparam int LFSR_W = 16;

  // Galois taps 16,14,13,11 for a right-shifting register (bit 0 is the output).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/vc_test_source_chan.sv
// One test-source channel: message memory, load count, stream FSM and delay LFSR.
// Latency: val rises d+1 cycles after start is sampled, d = LFSR draw (0 when p_max_delay=0).
// Backpressure: val/msg held stable in SEND until rdy; val never drops without a transfer.
// Ports: clk/reset (sync, active-low), start_i, write port we_i/widx_i/wmsg_i,
//        stream rdy_i/val_o/msg_o, sticky done_o.
module vc_test_source_chan
  import vc_test_source_pkg::*;
#(
  parameter int                p_msg_nbits = 32,
  parameter int                p_num_msgs  = 1024,
  parameter int                p_max_delay = 0,
  parameter logic [LFSR_W-1:0] p_seed      = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          we_i,
  input  logic [$clog2(p_num_msgs)-1:0] widx_i,
  input  logic [p_msg_nbits-1:0]        wmsg_i,
  input  logic                          rdy_i,
  output logic                          val_o,
  output logic [p_msg_nbits-1:0]        msg_o,
  output logic                          done_o
);

  localparam int IW = $clog2(p_num_msgs);
  localparam int CW = IW + 1;
  localparam int DW = $clog2(p_max_delay + 2);

  state_e                  state_q;
  logic [IW-1:0]           index_q;
  logic [CW-1:0]           count_q;
  logic [DW-1:0]           ctr_q;
  logic [LFSR_W-1:0]       lfsr_q;
  logic                    val_q;
  logic                    done_q;
  logic [p_msg_nbits-1:0]  mem_q [p_num_msgs];

  logic                    wr_ok;
  logic [CW-1:0]           wr_count;
  logic                    last;
  logic [DW-1:0]           draw;

  // Loads only land while the channel is idle so a stream never sees its memory change.
  assign wr_ok    = we_i && (state_q == IDLE);
  assign wr_count = CW'(widx_i) + CW'(1);
  assign last     = (CW'(index_q) == count_q - CW'(1));
  assign draw     = DW'(lfsr_q % LFSR_W'(p_max_delay + 1));

  // Memory has no reset: contents survive reset so a stream can be replayed.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem_q[widx_i] <= wmsg_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      index_q <= '0;
      count_q <= '0;
      ctr_q   <= '0;
      lfsr_q  <= p_seed;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      // Count tracks the highest index written so far, never shrinks.
      if (wr_ok && (wr_count > count_q)) count_q <= wr_count;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (count_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (draw == '0) begin
              state_q <= SEND;
              val_q   <= 1'b1;
            end else begin
              state_q <= DELAY;
              ctr_q   <= draw;
            end
          end
        end
        DELAY: begin
          if (ctr_q == DW'(1)) begin
            state_q <= SEND;
            val_q   <= 1'b1;
          end else begin
            ctr_q <= ctr_q - DW'(1);
          end
        end
        SEND: begin
          if (rdy_i) begin
            if (last) begin
              state_q <= DONE;
              val_q   <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              index_q <= index_q + IW'(1);
              if (draw != '0) begin
                state_q <= DELAY;
                val_q   <= 1'b0;
                ctr_q   <= draw;
              end
            end
          end
        end
        DONE: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign val_o  = val_q;
  assign done_o = done_q;
  assign msg_o  = mem_q[index_q];

  // A write aimed at a busy channel is dropped; flag it.
  always @(posedge clk) begin
    if (reset) begin
      assert (!we_i || (state_q == IDLE));
    end
  end

endmodule

// File: rtl/vc_test_source_multi.sv
// Multi-channel val/rdy test source; each channel streams its loaded messages after start.
// Latency: per channel, val rises d+1 cycles after start (d = per-channel LFSR delay draw).
// Backpressure: per-channel rdy; a stalled channel holds val and msg, others are unaffected.
// Ports: clk/reset (sync, active-low), start, load port ld_en/ld_chan/ld_idx/ld_msg,
//        per-channel val/rdy/done, flattened msg, all_done.
module vc_test_source_multi
  import vc_test_source_pkg::*;
#(
  parameter int                p_msg_nbits = 32,
  parameter int                p_num_msgs  = 1024,
  parameter int                p_num_chans = 2,
  parameter int                p_max_delay = 0,
  parameter logic [LFSR_W-1:0] p_seed      = 16'hACE1
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic                                                  ld_en,
  input  logic [(p_num_chans > 1 ? $clog2(p_num_chans) : 1)-1:0] ld_chan,
  input  logic [$clog2(p_num_msgs)-1:0]                         ld_idx,
  input  logic [p_msg_nbits-1:0]                                ld_msg,
  output logic [p_num_chans-1:0]                                val,
  input  logic [p_num_chans-1:0]                                rdy,
  output logic [p_num_chans*p_msg_nbits-1:0]                    msg,
  output logic [p_num_chans-1:0]                                done,
  output logic                                                  all_done
);

  logic [p_num_chans-1:0] we;

  for (genvar c = 0; c < p_num_chans; c++) begin : g_chan
    assign we[c] = ld_en && (32'(ld_chan) == c);

    vc_test_source_chan #(
      .p_msg_nbits (p_msg_nbits),
      .p_num_msgs  (p_num_msgs),
      .p_max_delay (p_max_delay),
      .p_seed      (p_seed ^ LFSR_W'(c))
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .start_i (start),
      .we_i    (we[c]),
      .widx_i  (ld_idx),
      .wmsg_i  (ld_msg),
      .rdy_i   (rdy[c]),
      .val_o   (val[c]),
      .msg_o   (msg[c*p_msg_nbits +: p_msg_nbits]),
      .done_o  (done[c])
    );
  end

  assign all_done = &done;

  always @(posedge clk) begin
    if (reset) begin
      assert (!ld_en || (32'(ld_chan) < p_num_chans));
      assert (!$isunknown(val));
      assert (!$isunknown(rdy));
      for (int c = 0; c < p_num_chans; c++) begin
        if (val[c]) assert (!$isunknown(msg[c*p_msg_nbits +: p_msg_nbits]));
      end
    end
  end

endmodule

// File: tb/tb_vc_test_source_multi.sv
// Bench for vc_test_source_multi: two instances (no delay / max delay 3) driven by the
// same stimulus; table rows for fixed sequences, a queue scoreboard for random streams.
module tb_vc_test_source_multi;

  localparam int W = 32;
  localparam int N = 16;
  localparam int C = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, start, ld_en, ld_chan;
  logic [3:0]     ld_idx;
  logic [W-1:0]   ld_msg;
  logic [C-1:0]   rdy;
  logic [C-1:0]   val_a, val_b, done_a, done_b;
  logic [C*W-1:0] msg_a, msg_b;
  logic           all_done_a, all_done_b;

  vc_test_source_multi #(.p_msg_nbits(W), .p_num_msgs(N), .p_num_chans(C),
                         .p_max_delay(0), .p_seed(16'hACE1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_chan(ld_chan),
    .ld_idx(ld_idx), .ld_msg(ld_msg), .val(val_a), .rdy(rdy), .msg(msg_a),
    .done(done_a), .all_done(all_done_a));

  vc_test_source_multi #(.p_msg_nbits(W), .p_num_msgs(N), .p_num_chans(C),
                         .p_max_delay(3), .p_seed(16'hACE1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_chan(ld_chan),
    .ld_idx(ld_idx), .ld_msg(ld_msg), .val(val_b), .rdy(rdy), .msg(msg_b),
    .done(done_b), .all_done(all_done_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; ld_en = 1'b0; rdy = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic load(input int c, input int idx, input logic [W-1:0] m);
    ld_en = 1'b1; ld_chan = 1'(c); ld_idx = 4'(idx); ld_msg = m;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- table-driven single-channel sequences (instance A, ch0) -------------
  typedef struct {
    logic         rdy;
    logic         val;
    logic [W-1:0] msg;
    logic         done;
    logic         alld;
  } vec_t;
  vec_t tv [10];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("row%0d val", i), val_a[0], tv[i].val);
      if (tv[i].val) chk($sformatf("row%0d msg", i), msg_a[W-1:0], tv[i].msg);
      chk($sformatf("row%0d done", i), done_a[0], tv[i].done);
      chk($sformatf("row%0d all_done", i), all_done_a, tv[i].alld);
      chk($sformatf("row%0d empty_val", i), val_a[1], 1'b0);
      chk($sformatf("row%0d empty_done", i), done_a[1], 1'b1);
      rdy = {1'b0, tv[i].rdy};
      tick();
    end
  endtask

  // ---------------- scoreboard monitor for both instances ----------------
  logic           mon_en = 1'b0;
  logic [C-1:0]   val_x [2];
  logic [C*W-1:0] msg_x [2];
  assign val_x[0] = val_a;
  assign val_x[1] = val_b;
  assign msg_x[0] = msg_a;
  assign msg_x[1] = msg_b;

  logic [W-1:0] exp_q [2*C][$];
  int           gap_q [$];
  int           gap_ref [$];
  int           idle_cnt [2*C];
  logic         prev_stall [2*C];
  logic [W-1:0] prev_msg [2*C];
  int           mk;
  logic         mv;
  logic [W-1:0] mm;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < C; c++) begin
        mk = d*C + c;
        mv = val_x[d][c];
        mm = msg_x[d][c*W +: W];
        if (!mon_en) begin
          idle_cnt[mk] = 0;
          prev_stall[mk] = 1'b0;
        end else begin
          if (prev_stall[mk]) begin
            chk($sformatf("stall_val d%0d c%0d", d, c), mv, 1'b1);
            chk($sformatf("stall_msg d%0d c%0d", d, c), mm, prev_msg[mk]);
          end
          if (!mv) begin
            idle_cnt[mk]++;
          end else if (rdy[c]) begin
            if (exp_q[mk].size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL extra_xfer d%0d c%0d: got 0x%0h, expected no transfer", d, c, mm);
            end else begin
              chk($sformatf("xfer_msg d%0d c%0d", d, c), mm, exp_q[mk].pop_front());
            end
            n_cmp++;
            if (idle_cnt[mk] > (d == 1 ? 3 : 0)) begin
              n_err++;
              $display("FAIL gap d%0d c%0d: got %0d idle cycles, required <= %0d",
                       d, c, idle_cnt[mk], (d == 1 ? 3 : 0));
            end
            if (d == 1) gap_q.push_back(c*100 + idle_cnt[mk]);
            idle_cnt[mk] = 0;
          end
          prev_stall[mk] = mv && !rdy[c];
          prev_msg[mk]   = mm;
        end
      end
    end
  end

  logic [W-1:0] arr [C][N];
  int           cnt [C];
  logic [W-1:0] m;

  task automatic stream_until_done(input int budget, input string tag);
    int k;
    mon_en = 1'b1;
    for (k = 0; k < budget; k++) begin
      tick();
      if (all_done_a && all_done_b) break;
      if (tag == "rand") rdy = 2'($urandom_range(0, 3));
    end
    mon_en = 1'b0;
    chk({tag, " all_done"}, {all_done_a, all_done_b}, 2'b11);
    for (int q = 0; q < 2*C; q++) begin
      chk($sformatf("%s leftover q%0d", tag, q), exp_q[q].size(), 0);
      exp_q[q].delete();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ld_en = 1'b0; ld_chan = 1'b0;
    ld_idx = '0; ld_msg = '0; rdy = '0;

    tv[0] = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b0};
    tv[2] = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0};
    tv[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
    tv[4] = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b0};
    tv[5] = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b0};
    tv[6] = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b0};
    tv[7] = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b0};
    tv[8] = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0};
    tv[9] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1};

    // Reset state
    tick(); tick();
    chk("rst val_a", val_a, 2'b00);
    chk("rst done_a", done_a, 2'b00);
    chk("rst all_done_a", all_done_a, 1'b0);
    chk("rst val_b", val_b, 2'b00);
    chk("rst done_b", done_b, 2'b00);

    // Back-to-back stream, then back-pressure on the second message; ch1 empty throughout
    do_reset();
    load(0, 0, 32'h11); load(0, 1, 32'h22); load(0, 2, 32'h33);
    pulse_start();
    run_rows(0, 3);
    do_reset();
    load(0, 0, 32'h11); load(0, 1, 32'h22); load(0, 2, 32'h33);
    pulse_start();
    run_rows(4, 9);

    // Two channels, 2 and 5 messages
    do_reset();
    load(0, 0, 32'hA0); load(0, 1, 32'hA1);
    for (int i = 0; i < 5; i++) load(1, i, 32'hB0 + i);
    rdy = 2'b11;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("two_ch c%0d val", k), val_a, {k < 5, k < 2});
      if (k < 2) chk($sformatf("two_ch c%0d msg0", k), msg_a[W-1:0], 32'hA0 + k);
      if (k < 5) chk($sformatf("two_ch c%0d msg1", k), msg_a[2*W-1:W], 32'hB0 + k);
      chk($sformatf("two_ch c%0d done", k), done_a, {k >= 5, k >= 2});
      chk($sformatf("two_ch c%0d all_done", k), all_done_a, k >= 5);
      tick();
    end

    // Random delays: bounded gaps, order kept, gap sequence repeatable from reset
    for (int run = 0; run < 2; run++) begin
      do_reset();
      gap_q.delete();
      for (int i = 0; i < 8; i++) begin
        load(0, i, 32'h500 + i);
        exp_q[0].push_back(32'h500 + i); exp_q[C].push_back(32'h500 + i);
      end
      for (int i = 0; i < 3; i++) begin
        load(1, i, 32'h600 + i);
        exp_q[1].push_back(32'h600 + i); exp_q[C+1].push_back(32'h600 + i);
      end
      rdy = 2'b11;
      pulse_start();
      stream_until_done(200, "delay");
      chk($sformatf("delay run%0d xfers", run), gap_q.size(), 11);
      if (run == 0) begin
        gap_ref = gap_q;
      end else begin
        chk("gap_seq len", gap_q.size(), gap_ref.size());
        for (int i = 0; i < gap_q.size() && i < gap_ref.size(); i++)
          chk($sformatf("gap_seq[%0d]", i), gap_q[i], gap_ref[i]);
      end
    end

    // Reset mid-stream, restart without reload, then replay from retained memory
    do_reset();
    load(0, 0, 32'h11); load(0, 1, 32'h22); load(0, 2, 32'h33);
    rdy = 2'b01;
    pulse_start();
    chk("mid msg0", msg_a[W-1:0], 32'h11); tick();
    chk("mid msg1", msg_a[W-1:0], 32'h22); tick();
    reset = 1'b0;
    tick();
    chk("mid_rst val_a", val_a, 2'b00);
    chk("mid_rst done_a", done_a, 2'b00);
    chk("mid_rst all_done_a", all_done_a, 1'b0);
    chk("mid_rst val_b", val_b, 2'b00);
    chk("mid_rst done_b", done_b, 2'b00);
    tick();
    reset = 1'b1;
    rdy = 2'b11;
    pulse_start();
    chk("restart empty done", done_a, 2'b11);
    chk("restart empty val", val_a, 2'b00);
    tick();
    chk("restart empty val2", val_a, 2'b00);
    do_reset();
    load(0, 2, 32'h33);
    pulse_start();
    run_rows(0, 3);

    // Randomized streams with random rdy against the queue scoreboard
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < C; c++) begin
        cnt[c] = $urandom_range(0, 8);
        for (int i = 0; i < cnt[c]; i++) begin
          m = $urandom;
          arr[c][i] = m;
          load(c, i, m);
        end
        if (cnt[c] >= 2 && $urandom_range(0, 1) == 1) begin
          m = $urandom;
          arr[c][0] = m;
          load(c, 0, m);
        end
        for (int i = 0; i < cnt[c]; i++) begin
          exp_q[c].push_back(arr[c][i]);
          exp_q[C+c].push_back(arr[c][i]);
        end
      end
      rdy = 2'($urandom_range(0, 3));
      pulse_start();
      stream_until_done(400, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
